// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the fetch stage.
package pipe_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // Fetch-to-decode payload.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } f2d_t;

  localparam f2d_t F2D_RESET = '{instr: NOP_INSTR, pc: '0, valid: 1'b0};

  // Word-align a redirect target.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the PC, issues one instruction-memory
// request at a time over req/gnt/rvalid, and loads the F2D register.
// Decode stalls park a returned instruction in a hold buffer; execute
// redirects flush F2D and discard any in-flight stale response.
//
// Ports:
//   clk, rst           clock; synchronous active-low reset
//   br_taken           redirect pulse from execute
//   alu_output         redirect target (word-aligned internally)
//   stall_d            decode cannot accept, F2D holds
//   imem_req/addr      fetch request and address (addr == pc)
//   imem_gnt           request accepted
//   imem_rvalid/rdata  response valid and instruction word
//   InstrF2D/PCF2D/ValidF2D  fetch-to-decode register
module fetch_ctrl
  import pipe_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            br_taken,
  input  logic [XLEN-1:0] alu_output,
  input  logic            stall_d,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] InstrF2D,
  output logic [XLEN-1:0] PCF2D,
  output logic            ValidF2D
);

  fetch_state_t    state_q, state_nxt;
  logic [XLEN-1:0] pc_q, pc_nxt;
  logic            kill_q, kill_nxt;
  logic            req_q;
  f2d_t            f2d_q, f2d_nxt;
  f2d_t            hold_q, hold_nxt;

  logic            rsp_live_c;
  logic            load_direct_c;
  logic            load_hold_c;
  logic            capture_c;
  logic            drop_hold_c;
  logic            pc_inc_c;

  // Low target bits are discarded by word alignment.
  logic unused_alu_bits;
  assign unused_alu_bits = &{1'b0, alu_output[1:0]};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= REQ;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state_q;
    unique case (state_q)
      REQ: begin
        if (imem_gnt) state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (br_taken || kill_q) state_nxt = REQ;
          else if (stall_d)       state_nxt = HOLD;
          else                    state_nxt = REQ;
        end
      end
      HOLD: begin
        if (br_taken || !stall_d) state_nxt = REQ;
      end
      default: state_nxt = REQ;
    endcase
  end

  // Datapath controls and next values for pc, kill, hold buffer and F2D.
  always_comb begin
    rsp_live_c    = (state_q == WAIT) && imem_rvalid;
    load_direct_c = rsp_live_c && !kill_q && !br_taken && !stall_d;
    capture_c     = rsp_live_c && !kill_q && !br_taken && stall_d;
    load_hold_c   = (state_q == HOLD) && !br_taken && !stall_d && hold_q.valid;
    drop_hold_c   = (state_q == HOLD) && (br_taken || !stall_d);
    pc_inc_c      = load_direct_c || load_hold_c;

    pc_nxt = pc_q;
    if (br_taken)      pc_nxt = align_word(alu_output);
    else if (pc_inc_c) pc_nxt = pc_q + XLEN'(4);

    kill_nxt = kill_q;
    unique case (state_q)
      REQ:     if (br_taken && imem_gnt) kill_nxt = 1'b1;
      WAIT: begin
        if (imem_rvalid)   kill_nxt = 1'b0;
        else if (br_taken) kill_nxt = 1'b1;
      end
      HOLD:    kill_nxt = 1'b0;
      default: kill_nxt = 1'b0;
    endcase

    hold_nxt = hold_q;
    if (capture_c)        hold_nxt = '{instr: imem_rdata, pc: pc_q, valid: 1'b1};
    else if (drop_hold_c) hold_nxt = '0;

    // Redirect flushes even under stall; otherwise stall holds, idle bubbles.
    f2d_nxt = '{instr: NOP_INSTR, pc: f2d_q.pc, valid: 1'b0};
    if (br_taken)           f2d_nxt = '{instr: NOP_INSTR, pc: f2d_q.pc, valid: 1'b0};
    else if (load_direct_c) f2d_nxt = '{instr: imem_rdata, pc: pc_q, valid: 1'b1};
    else if (load_hold_c)   f2d_nxt = '{instr: hold_q.instr, pc: hold_q.pc, valid: 1'b1};
    else if (stall_d)       f2d_nxt = f2d_q;
  end

  // Datapath registers; imem_req is registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      kill_q <= 1'b0;
      req_q  <= 1'b1;
      hold_q <= '0;
      f2d_q  <= F2D_RESET;
    end else begin
      pc_q   <= pc_nxt;
      kill_q <= kill_nxt;
      req_q  <= (state_nxt == REQ);
      hold_q <= hold_nxt;
      f2d_q  <= f2d_nxt;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign InstrF2D  = f2d_q.instr;
  assign PCF2D     = f2d_q.pc;
  assign ValidF2D  = f2d_q.valid;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: memory handshake driven by hand, each
// step checked against hand-computed outputs.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] alu_output = '0;
  logic        stall_d = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] InstrF2D;
  logic [31:0] PCF2D;
  logic        ValidF2D;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .br_taken   (br_taken),
    .alu_output (alu_output),
    .stall_d    (stall_d),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .InstrF2D   (InstrF2D),
    .PCF2D      (PCF2D),
    .ValidF2D   (ValidF2D)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".req"}, 32'(imem_req), 32'(req));
    if (req) chk({tag, ".addr"}, imem_addr, addr);
  endtask

  task automatic chk_f2d(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                         input logic v);
    chk({tag, ".valid"}, 32'(ValidF2D), 32'(v));
    chk({tag, ".instr"}, InstrF2D, ins);
    chk({tag, ".pc"}, PCF2D, pc);
  endtask

  // Drive one cycle of inputs and sample #1 after the rising edge.
  task automatic step(input logic g, input logic rv, input logic [31:0] rd,
                      input logic b, input logic [31:0] alu, input logic st);
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = rd;
    br_taken    = b;
    alu_output  = alu;
    stall_d     = st;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    rst = 1'b0;
    @(posedge clk); #1;
    chk_if("rst", 1'b1, 32'h0);
    chk_f2d("rst", NOP, 32'h0, 1'b0);
    rst = 1'b1;

    // Zero-wait fetch loop
    step(1, 0, 0, 0, 0, 0);
    chk_if("f0_gnt", 1'b0, 32'h0);
    step(0, 1, 32'h00500093, 0, 0, 0);
    chk_f2d("f0_data", 32'h00500093, 32'h0, 1'b1);
    chk_if("f0_next", 1'b1, 32'h4);
    step(1, 0, 0, 0, 0, 0);
    chk_f2d("f1_bubble", NOP, 32'h0, 1'b0);
    step(0, 1, 32'h00a00113, 0, 0, 0);
    chk_f2d("f1_data", 32'h00a00113, 32'h4, 1'b1);
    chk_if("f1_next", 1'b1, 32'h8);

    // Decode stall over a returning fetch, with a spurious rvalid in HOLD
    step(1, 0, 0, 0, 0, 1);
    chk_f2d("st_gnt", 32'h00a00113, 32'h4, 1'b1);
    step(0, 1, 32'h00f00193, 0, 0, 1);
    chk_if("st_hold", 1'b0, 32'h8);
    chk_f2d("st_hold", 32'h00a00113, 32'h4, 1'b1);
    step(0, 1, 32'hdeadbeef, 0, 0, 1);
    chk_f2d("st_hold2", 32'h00a00113, 32'h4, 1'b1);
    step(0, 0, 0, 0, 0, 1);
    chk_if("st_hold3", 1'b0, 32'h8);
    step(0, 0, 0, 0, 0, 0);
    chk_f2d("st_rel", 32'h00f00193, 32'h8, 1'b1);
    chk_if("st_rel", 1'b1, 32'hC);

    // Redirect in WAIT without rvalid; stale response two cycles later
    step(1, 0, 0, 0, 0, 0);
    chk_f2d("bw_gnt", NOP, 32'h8, 1'b0);
    step(0, 0, 0, 1, 32'h0000_0102, 0);
    chk_if("bw_br", 1'b0, 32'h0);
    chk_f2d("bw_br", NOP, 32'h8, 1'b0);
    step(0, 0, 0, 0, 0, 0);
    chk_if("bw_w", 1'b0, 32'h0);
    step(0, 1, 32'hdeadbeef, 0, 0, 0);
    chk_f2d("bw_stale", NOP, 32'h8, 1'b0);
    chk_if("bw_stale", 1'b1, 32'h100);
    step(1, 0, 0, 0, 0, 0);
    chk_f2d("bw_gnt2", NOP, 32'h8, 1'b0);
    step(0, 1, 32'h01400213, 0, 0, 0);
    chk_f2d("bw_tgt", 32'h01400213, 32'h100, 1'b1);
    chk_if("bw_tgt", 1'b1, 32'h104);

    // Redirect together with gnt
    step(1, 0, 0, 1, 32'h0000_0200, 0);
    chk_if("bg_br", 1'b0, 32'h0);
    chk_f2d("bg_br", NOP, 32'h100, 1'b0);
    step(0, 1, 32'hdeadbeef, 0, 0, 0);
    chk_f2d("bg_stale", NOP, 32'h100, 1'b0);
    chk_if("bg_stale", 1'b1, 32'h200);

    // Redirect together with rvalid
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'hdeadbeef, 1, 32'h0000_0300, 0);
    chk_f2d("br_rv", NOP, 32'h100, 1'b0);
    chk_if("br_rv", 1'b1, 32'h300);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h01900293, 0, 0, 0);
    chk_f2d("br_tgt", 32'h01900293, 32'h300, 1'b1);

    // Redirect in REQ without gnt, with stall_d: redirect wins and flushes
    step(0, 0, 0, 1, 32'hFFFF_FFFE, 1);
    chk_f2d("bs_flush", NOP, 32'h300, 1'b0);
    chk_if("bs_flush", 1'b1, 32'hFFFF_FFFC);

    // PC wrap
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h01e00313, 0, 0, 0);
    chk_f2d("wrap", 32'h01e00313, 32'hFFFF_FFFC, 1'b1);
    chk_if("wrap", 1'b1, 32'h0);

    // Redirect out of HOLD drops the buffered instruction
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'hbad0bad0, 0, 0, 1);
    chk_if("bh_hold", 1'b0, 32'h0);
    step(0, 0, 0, 1, 32'h0000_0040, 1);
    chk_f2d("bh_br", NOP, 32'hFFFF_FFFC, 1'b0);
    chk_if("bh_br", 1'b1, 32'h40);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h02300393, 0, 0, 0);
    chk_f2d("bh_tgt", 32'h02300393, 32'h40, 1'b1);
    chk_if("bh_tgt", 1'b1, 32'h44);

    // Reset mid-WAIT with stall_d asserted
    step(1, 0, 0, 0, 0, 0);
    chk_if("rw_wait", 1'b0, 32'h0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 1);
    chk_if("rw_rst", 1'b1, 32'h0);
    chk_f2d("rw_rst", NOP, 32'h0, 1'b0);
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    chk_if("rw_rel", 1'b1, 32'h0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 32'h00500093, 0, 0, 0);
    chk_f2d("rw_fetch", 32'h00500093, 32'h0, 1'b1);
    chk_if("rw_fetch", 1'b1, 32'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
